// File: rtl/hr_inject_sched.sv
// Ring injection scheduler: shares one bufferless ring slot among NREQ FIFOs, ring traffic first, then round-robin.
// Latency: deQ_o is combinational in the grant cycle; slot_o/slot_valid_o/grant_id_o register one edge later.
// Backpressure: an occupied incoming slot blocks all injection; wait counters raise starve_o so upstream can open bubbles.
module hr_inject_sched #(
  parameter int NREQ       = 4,
  parameter int WIDTH      = 144,
  parameter int STARVE_LIM = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  slot_valid_i,
  input  logic [WIDTH-1:0]      slot_i,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] flit_i,
  output logic [NREQ-1:0]       deQ_o,
  output logic                  slot_valid_o,
  output logic [WIDTH-1:0]      slot_o,
  output logic [2:0]            grant_id_o,
  output logic                  starve_o
);

  localparam int              PW     = $clog2(NREQ);
  localparam logic [PW:0]     NREQ_W = (PW+1)'(NREQ);
  localparam logic [PW-1:0]   LAST   = PW'(NREQ - 1);
  localparam logic [7:0]      LIM    = 8'(STARVE_LIM);

  logic [PW-1:0]    ptr;
  logic [7:0]       wait_cnt [NREQ];
  logic             grant_vld;
  logic [PW-1:0]    grant_idx;
  logic [PW:0]      scan_idx;
  logic [WIDTH-1:0] grant_flit;

  // Round-robin search: first requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_idx = {1'b0, ptr} + (PW+1)'(i);
      if (scan_idx >= NREQ_W) begin
        scan_idx = scan_idx - NREQ_W;
      end
      if (!grant_vld && req_i[scan_idx[PW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx[PW-1:0];
      end
    end
  end

  // Select the granted FIFO's head flit.
  always_comb begin
    grant_flit = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant_idx == PW'(k)) begin
        grant_flit = flit_i[k*WIDTH +: WIDTH];
      end
    end
  end

  // Pop strobe: only when the ring slot is free, never during reset, at most one-hot.
  always_comb begin
    deQ_o = '0;
    if (!rst && !slot_valid_i && grant_vld) begin
      deQ_o[grant_idx] = 1'b1;
    end
  end

  // Output slot register: passthrough beats inject; idle drives an empty, zeroed slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid_o <= 1'b0;
      slot_o       <= '0;
      grant_id_o   <= '0;
      ptr          <= '0;
    end else if (slot_valid_i) begin
      slot_valid_o <= 1'b1;
      slot_o       <= slot_i;
    end else if (grant_vld) begin
      slot_valid_o <= 1'b1;
      slot_o       <= grant_flit;
      grant_id_o   <= 3'(grant_idx);
      ptr          <= (grant_idx == LAST) ? '0 : grant_idx + 1'b1;
    end else begin
      slot_valid_o <= 1'b0;
      slot_o       <= '0;
    end
  end

  // Per-requester blocked-cycle counters, cleared when idle or served, saturating at 255.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREQ; k++) begin
        wait_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_i[k] || deQ_o[k]) begin
          wait_cnt[k] <= '0;
        end else if (wait_cnt[k] != 8'hFF) begin
          wait_cnt[k] <= wait_cnt[k] + 8'd1;
        end
      end
    end
  end

  // Starvation flag decoded only from registered counters, so it cannot glitch on input changes.
  always_comb begin
    starve_o = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (wait_cnt[k] >= LIM) begin
        starve_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hr_inject_sched.sv
// Directed bench for hr_inject_sched with NREQ=4 and STARVE_LIM=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled 1-2 units after the edge.
// FIFO heads are constant: FIFO k always presents 0xA0+k.
module tb_hr_inject_sched;
  localparam int N = 4;
  localparam int W = 144;

  logic           clk = 1'b0;
  logic           rst;
  logic           slot_valid_i;
  logic [W-1:0]   slot_i;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] flit_i;
  logic [N-1:0]   deQ_o;
  logic           slot_valid_o;
  logic [W-1:0]   slot_o;
  logic [2:0]     grant_id_o;
  logic           starve_o;

  int errors = 0;
  int checks = 0;

  hr_inject_sched #(.NREQ(N), .WIDTH(W), .STARVE_LIM(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .slot_valid_i (slot_valid_i),
    .slot_i       (slot_i),
    .req_i        (req_i),
    .flit_i       (flit_i),
    .deQ_o        (deQ_o),
    .slot_valid_o (slot_valid_o),
    .slot_o       (slot_o),
    .grant_id_o   (grant_id_o),
    .starve_o     (starve_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; slot_valid_i = 1'b0; slot_i = '0; req_i = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] ef;
    rst = 1'b1; slot_valid_i = 1'b0; slot_i = '0; req_i = 4'b1111;
    @(posedge clk); #1;
    checks++; if (deQ_o !== 4'b0000) begin errors++; $display("FAIL rst_deq got=%b exp=0000", deQ_o); end
    checks++; if (slot_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", slot_valid_o); end
    checks++; if (slot_o !== '0) begin errors++; $display("FAIL rst_slot got=%0h exp=0", slot_o); end
    checks++; if (grant_id_o !== 3'd0) begin errors++; $display("FAIL rst_gid got=%0d exp=0", grant_id_o); end
    checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL rst_starve got=%b exp=0", starve_o); end
    // Two grants (0 then 1) leave ptr=2 with an occupied output slot.
    rst = 1'b0; req_i = 4'b0011;
    #1;
    checks++; if (deQ_o !== 4'b0001) begin errors++; $display("FAIL rst_pre_deq0 got=%b exp=0001", deQ_o); end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (slot_valid_o !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%b exp=1", slot_valid_o); end
    checks++; if (grant_id_o !== 3'd1) begin errors++; $display("FAIL rst_pre_gid got=%0d exp=1", grant_id_o); end
    // Asynchronous assertion mid-cycle.
    rst = 1'b1;
    #1;
    checks++; if (slot_valid_o !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", slot_valid_o); end
    checks++; if (slot_o !== '0) begin errors++; $display("FAIL arst_slot got=%0h exp=0", slot_o); end
    checks++; if (grant_id_o !== 3'd0) begin errors++; $display("FAIL arst_gid got=%0d exp=0", grant_id_o); end
    checks++; if (deQ_o !== 4'b0000) begin errors++; $display("FAIL arst_deq got=%b exp=0000", deQ_o); end
    rst = 1'b0; req_i = 4'b0100;
    #1;
    checks++; if (deQ_o !== 4'b0100) begin errors++; $display("FAIL post_rst_deq got=%b exp=0100", deQ_o); end
    @(posedge clk); #1;
    req_i = '0;
    ef = W'(32'hA2);
    checks++; if (grant_id_o !== 3'd2) begin errors++; $display("FAIL post_rst_gid got=%0d exp=2", grant_id_o); end
    checks++; if (slot_o !== ef) begin errors++; $display("FAIL post_rst_slot got=%0h exp=%0h", slot_o, ef); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] ed;
    logic [W-1:0] ef;
    do_reset();
    req_i = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      ed = 4'b0001 << (i % 4);
      ef = W'(32'hA0 + (i % 4));
      #1;
      checks++; if (deQ_o !== ed) begin errors++; $display("FAIL rr_deq[%0d] got=%b exp=%b", i, deQ_o, ed); end
      @(posedge clk); #1;
      checks++; if (slot_o !== ef || slot_valid_o !== 1'b1) begin errors++; $display("FAIL rr_slot[%0d] got=%0h/%b exp=%0h/1", i, slot_o, slot_valid_o, ef); end
      checks++; if (grant_id_o !== 3'(i % 4)) begin errors++; $display("FAIL rr_gid[%0d] got=%0d exp=%0d", i, grant_id_o, i % 4); end
    end
    checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL rr_starve got=%b exp=0", starve_o); end
    req_i = '0;
  endtask

  task automatic test_passthrough_starve();
    logic [W-1:0] ep;
    logic         es;
    do_reset();
    ep = W'(32'h185f);
    slot_valid_i = 1'b1; slot_i = ep; req_i = 4'b0010;
    for (int e = 1; e <= 4; e++) begin
      es = (e >= 4);
      #1;
      checks++; if (deQ_o !== 4'b0000) begin errors++; $display("FAIL pt_deq[%0d] got=%b exp=0000", e, deQ_o); end
      @(posedge clk); #1;
      checks++; if (slot_o !== ep || slot_valid_o !== 1'b1) begin errors++; $display("FAIL pt_slot[%0d] got=%0h/%b exp=%0h/1", e, slot_o, slot_valid_o, ep); end
      checks++; if (grant_id_o !== 3'd0) begin errors++; $display("FAIL pt_gid[%0d] got=%0d exp=0", e, grant_id_o); end
      checks++; if (starve_o !== es) begin errors++; $display("FAIL pt_starve[%0d] got=%b exp=%b", e, starve_o, es); end
    end
    slot_valid_i = 1'b0; slot_i = '0;
    #1;
    checks++; if (deQ_o !== 4'b0010) begin errors++; $display("FAIL st_deq got=%b exp=0010", deQ_o); end
    checks++; if (starve_o !== 1'b1) begin errors++; $display("FAIL st_hold got=%b exp=1", starve_o); end
    @(posedge clk); #1;
    req_i = '0;
    ep = W'(32'hA1);
    checks++; if (starve_o !== 1'b0) begin errors++; $display("FAIL st_clear got=%b exp=0", starve_o); end
    checks++; if (slot_o !== ep || grant_id_o !== 3'd1) begin errors++; $display("FAIL st_slot got=%0h/%0d exp=%0h/1", slot_o, grant_id_o, ep); end
  endtask

  task automatic test_wrap();
    int           seq [3] = '{3, 0, 3};
    logic [N-1:0] ed;
    logic [W-1:0] ef;
    do_reset();
    req_i = 4'b0100;
    #1;
    checks++; if (deQ_o !== 4'b0100) begin errors++; $display("FAIL wrap_pre_deq got=%b exp=0100", deQ_o); end
    @(posedge clk); #1;
    req_i = 4'b1001;
    for (int j = 0; j < 3; j++) begin
      ed = 4'b0001 << seq[j];
      ef = W'(32'hA0 + seq[j]);
      #1;
      checks++; if (deQ_o !== ed) begin errors++; $display("FAIL wrap_deq[%0d] got=%b exp=%b", j, deQ_o, ed); end
      @(posedge clk); #1;
      checks++; if (grant_id_o !== 3'(seq[j]) || slot_o !== ef) begin errors++; $display("FAIL wrap_out[%0d] got=%0d/%0h exp=%0d/%0h", j, grant_id_o, slot_o, seq[j], ef); end
    end
    req_i = '0;
  endtask

  task automatic test_idle();
    do_reset();
    req_i = 4'b0010;
    @(posedge clk); #1;
    req_i = '0;
    #1;
    checks++; if (deQ_o !== 4'b0000) begin errors++; $display("FAIL idle_deq got=%b exp=0000", deQ_o); end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      checks++; if (slot_valid_o !== 1'b0 || slot_o !== '0) begin errors++; $display("FAIL idle_slot[%0d] got=%b/%0h exp=0/0", c, slot_valid_o, slot_o); end
      checks++; if (grant_id_o !== 3'd1) begin errors++; $display("FAIL idle_gid[%0d] got=%0d exp=1", c, grant_id_o); end
    end
    req_i = 4'b1111;
    #1;
    checks++; if (deQ_o !== 4'b0100) begin errors++; $display("FAIL idle_ptr got=%b exp=0100", deQ_o); end
    @(posedge clk); #1;
    req_i = '0;
    checks++; if (grant_id_o !== 3'd2) begin errors++; $display("FAIL idle_after_gid got=%0d exp=2", grant_id_o); end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      flit_i[k*W +: W] = W'(32'hA0 + k);
    end
    test_reset();
    test_round_robin();
    test_passthrough_starve();
    test_wrap();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
